sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock first-in/first-out buffer with registered read data and full/empty status flags. It decouples a word producer from a consumer that run in the same clock domain, e.g. staging command or data words ahead of a serial engine. Storage depth and word width are parameters; occupancy is tracked with a counter alongside wrapping read and write pointers.

## Interface
- FIFO_DEPTH, 4: number of storage words; must be a power of two, ≥ 2.
- DATA_WIDTH, 15: width of each stored word in bits.
- Internal state widths: PTR_W = $clog2(FIFO_DEPTH)+1 bits. Signals rd_pointer, wr_pointer and status_cnt are each PTR_W bits and carry exactly these names for hierarchical probing.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- arst  input  1  reset; asynchronous and active-high.
- wr_en  input  1  write request for the current cycle.
- rd_en  input  1  read request for the current cycle.
- data_in  input  DATA_WIDTH  write data, sampled on a rising edge when a write is accepted.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when status_cnt == FIFO_DEPTH.
- empty  output  1  high when status_cnt == 0.

## Operation
- Storage is an array of FIFO_DEPTH words of DATA_WIDTH bits. The array is not reset.
- Write acceptance: wr_ok = wr_en & ~full.
  - On a write, mem[wr_pointer[PTR_W-2:0]] <= data_in.
  - wr_pointer increments modulo 2*FIFO_DEPTH; the extra MSB is the wrap bit.
- Read acceptance: rd_ok = rd_en & ~empty.
  - On a read, data_out <= mem[rd_pointer[PTR_W-2:0]].
  - rd_pointer increments modulo 2*FIFO_DEPTH.
- A write while full is dropped silently: no pointer, count or memory change.
- A read while empty is ignored: data_out holds its previous value.
- Occupancy: status_cnt <= status_cnt + wr_ok - rd_ok. Range is 0..FIFO_DEPTH, with no overflow or underflow.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both are performed and the count is unchanged.
  - Empty: only the write is performed, and the count becomes 1.
  - Full: only the read is performed, and the count becomes FIFO_DEPTH-1.
- full and empty are combinational decodes of status_cnt. They are never both high.
- Ordering is strict FIFO across pointer wrap-around.

## Timing
- Reset (arst high) takes effect immediately, without waiting for a clock edge:
  - wr_pointer, rd_pointer and status_cnt go to 0.
  - data_out goes to 0.
  - empty = 1, full = 0.
- Reset asserted mid-operation discards all stored contents. Outputs take their reset values while arst is high.
- The first rising edge after arst falls may accept a write or read.
- Write-to-flag latency: empty deasserts, and full asserts, in the same cycle that status_cnt updates, one edge after the accepted request.
- Read latency: data_out is valid one edge after the accepted rd_en and remains stable until the next accepted read.
- Write-to-read: a word written at edge N may be read at edge N+1 at the earliest. There is no fall-through from data_in to data_out.
- Flags are evaluated from the state before the edge. A read does not free space for a write in the same cycle when the FIFO is full, and vice versa when empty.

## Test plan
- Reset: pulse arst for 1 cycle -> data_out = 0, empty = 1, full = 0, status_cnt = 0, both pointers = 0.
- Fill plus overflow: hold wr_en for 5 edges with data 0x0011, 0x0022, 0x0033, 0x0044, 0x0055 -> full = 1 after the 4th edge, status_cnt = 4, 0x0055 dropped, wr_pointer = 4.
- Drain: then hold rd_en for 4 edges -> data_out shows 0x0011, 0x0022, 0x0033, 0x0044 on successive edges; empty = 1 after the 4th; rd_pointer = 4 (wrap bit set).
- Underflow: a further rd_en for 2 edges while empty -> data_out holds 0x0044, with count and pointers unchanged.
- Wrap-around plus simultaneous access: write 3 words, then assert wr_en and rd_en together for 6 edges with an incrementing data pattern -> status_cnt stays 3, output order matches input order, and the pointers pass through 7 -> 0 correctly.
- Async reset mid-stream: assert arst between edges while status_cnt = 2 -> empty = 1 and data_out = 0 immediately, before the next clock edge; subsequent writes restart at address 0.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, occupancy counter
// and wrapping read/write pointers (extra MSB is the wrap bit).
module sync_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ADDR_W = PTR_W - 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_pointer;
  logic [PTR_W-1:0]      rd_pointer;
  logic [PTR_W-1:0]      status_cnt;
  logic                  wr_ok;
  logic                  rd_ok;

  // Status flags decoded from the pre-edge occupancy
  assign full  = (status_cnt == PTR_W'(FIFO_DEPTH));
  assign empty = (status_cnt == PTR_W'(0));

  // Requests are qualified by the flags, so a full FIFO drops writes and an empty one ignores reads
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // Storage array; intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_pointer[ADDR_W-1:0]] <= data_in;
    end
  end

  // Pointers wrap modulo 2*FIFO_DEPTH through natural PTR_W-bit overflow
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_pointer <= '0;
      rd_pointer <= '0;
    end else begin
      if (wr_ok) wr_pointer <= wr_pointer + PTR_W'(1);
      if (rd_ok) rd_pointer <= rd_pointer + PTR_W'(1);
    end
  end

  // Occupancy counter: unchanged when both or neither request is accepted
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      status_cnt <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   status_cnt <= status_cnt + PTR_W'(1);
        2'b01:   status_cnt <= status_cnt - PTR_W'(1);
        default: status_cnt <= status_cnt;
      endcase
    end
  end

  // Registered read data; holds its value when no read is accepted
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      data_out <= '0;
    end else if (rd_ok) begin
      data_out <= mem[rd_pointer[ADDR_W-1:0]];
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed checks of sync_fifo with hand-computed expectations.
module tb_sync_fifo;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DATA_WIDTH = 15;

  logic                  clk;
  logic                  arst;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;

  int total;
  int bad;

  sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk      (clk),
    .arst     (arst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    arst    = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;

    // Reset pulse
    #2 arst = 1'b1;
    tick();
    arst = 1'b0;
    chk("rst_dout",  32'(data_out), 32'h0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full), 32'd0);
    chk("rst_cnt",   32'(dut.status_cnt), 32'd0);
    chk("rst_wptr",  32'(dut.wr_pointer), 32'd0);
    chk("rst_rptr",  32'(dut.rd_pointer), 32'd0);

    // Fill plus one overflowing write
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = DATA_WIDTH'(32'h11 * (i + 1));
      tick();
      chk("fill_cnt",  32'(dut.status_cnt), (i < 4) ? 32'(i + 1) : 32'd4);
      chk("fill_full", 32'(full), (i >= 3) ? 32'd1 : 32'd0);
      chk("fill_empty", 32'(empty), 32'd0);
    end
    wr_en = 1'b0;
    chk("fill_wptr", 32'(dut.wr_pointer), 32'd4);

    // Drain in order; the dropped 0x55 never appears
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_dout",  32'(data_out), 32'h11 * (i + 1));
      chk("drain_empty", 32'(empty), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("drain_rptr", 32'(dut.rd_pointer), 32'd4);

    // Underflow: reads while empty are ignored
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("under_dout", 32'(data_out), 32'h44);
      chk("under_cnt",  32'(dut.status_cnt), 32'd0);
    end
    chk("under_rptr", 32'(dut.rd_pointer), 32'd4);
    chk("under_wptr", 32'(dut.wr_pointer), 32'd4);
    rd_en = 1'b0;

    // Preload three words, then simultaneous access across pointer wrap
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = DATA_WIDTH'(32'h100 + i);
      tick();
    end
    chk("pre_cnt",  32'(dut.status_cnt), 32'd3);
    chk("pre_wptr", 32'(dut.wr_pointer), 32'd7);
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = DATA_WIDTH'(32'h103 + i);
      tick();
      chk("wrap_dout", 32'(data_out), 32'h100 + i);
      chk("wrap_cnt",  32'(dut.status_cnt), 32'd3);
      chk("wrap_wptr", 32'(dut.wr_pointer), 32'((7 + i + 1) % 8));
      chk("wrap_rptr", 32'(dut.rd_pointer), 32'((4 + i + 1) % 8));
    end
    wr_en = 1'b0;

    // One more read leaves two words stored
    tick();
    rd_en = 1'b0;
    chk("pre_rst_dout", 32'(data_out), 32'h106);
    chk("pre_rst_cnt",  32'(dut.status_cnt), 32'd2);

    // Asynchronous reset between edges takes effect immediately
    #2 arst = 1'b1;
    #1;
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full",  32'(full), 32'd0);
    chk("arst_dout",  32'(data_out), 32'h0);
    chk("arst_cnt",   32'(dut.status_cnt), 32'd0);
    chk("arst_wptr",  32'(dut.wr_pointer), 32'd0);
    arst = 1'b0;

    // Simultaneous request while empty: only the write happens
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = DATA_WIDTH'(32'h0aa);
    tick();
    chk("emp_both_cnt",  32'(dut.status_cnt), 32'd1);
    chk("emp_both_dout", 32'(data_out), 32'h0);
    chk("emp_both_wptr", 32'(dut.wr_pointer), 32'd1);
    chk("emp_both_rptr", 32'(dut.rd_pointer), 32'd0);
    chk("emp_both_mem0", 32'(dut.mem[0]), 32'h0aa);
    wr_en = 1'b0;
    tick();
    chk("restart_dout",  32'(data_out), 32'h0aa);
    chk("restart_empty", 32'(empty), 32'd1);
    rd_en = 1'b0;

    // Fill, then simultaneous request while full: only the read happens
    wr_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = DATA_WIDTH'(32'h201 + i);
      tick();
    end
    chk("full2_full", 32'(full), 32'd1);
    rd_en   = 1'b1;
    data_in = DATA_WIDTH'(32'h2ff);
    tick();
    chk("full_both_cnt",  32'(dut.status_cnt), 32'd3);
    chk("full_both_dout", 32'(data_out), 32'h201);
    chk("full_both_full", 32'(full), 32'd0);
    wr_en = 1'b0;

    // Remaining words come out in order without the dropped 0x2ff
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tail_dout", 32'(data_out), 32'h202 + i);
    end
    chk("tail_empty", 32'(empty), 32'd1);
    rd_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
